// File: rtl/rf_pkg.sv
// Shared definitions for the 32-entry integer register file.
// Address type and the hardwired-zero register index.
package rf_pkg;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/decoder32.sv
// 5-to-32 one-hot decoder with enable.
// All outputs are low whenever ena is low.
module decoder32
  import rf_pkg::*;
(
  input  reg_addr_t              in,
  input  logic                   ena,
  output logic [REG_COUNT-1:0]   out
);

  always_comb begin
    out = '0;
    if (ena) out[in] = 1'b1;
  end

endmodule

// File: rtl/register_file_32x.sv
// 32 x N register file with x0 hardwired to zero.
// Two combinational read ports with optional write bypass.
module register_file_32x
  import rf_pkg::*;
#(
  parameter int           N           = 32,
  parameter bit           BYPASS      = 1'b1,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_ena,
  input  reg_addr_t       wr_addr,
  input  logic [N-1:0]    wr_data,
  input  reg_addr_t       rd_addr0,
  output logic [N-1:0]    rd_data0,
  input  reg_addr_t       rd_addr1,
  output logic [N-1:0]    rd_data1
);

  logic [REG_COUNT-1:0] we;
  logic [N-1:0]         regs_q [1:REG_COUNT-1];
  logic [N-1:0]         regs_d [1:REG_COUNT-1];
  logic [N-1:0]         rf     [REG_COUNT];
  logic                 fwd0;
  logic                 fwd1;
  logic                 unused_we0;

  decoder32 u_dec (
    .in  (wr_addr),
    .ena (wr_ena),
    .out (we)
  );

  // x0 has no storage, so its decoder line goes nowhere
  assign unused_we0 = we[0];

  always_comb begin
    for (int k = 1; k < REG_COUNT; k++) begin
      regs_d[k] = regs_q[k];
      if (we[k]) regs_d[k] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k < REG_COUNT; k++)
        regs_q[k] <= RESET_VALUE;
    end else begin
      for (int k = 1; k < REG_COUNT; k++)
        regs_q[k] <= regs_d[k];
    end
  end

  always_comb begin
    rf[0] = '0;
    for (int k = 1; k < REG_COUNT; k++)
      rf[k] = regs_q[k];
  end

  // forwarding never targets x0, so it still reads zero
  assign fwd0 = BYPASS && wr_ena && (wr_addr != ZERO_REG)
                && (rd_addr0 == wr_addr);
  assign fwd1 = BYPASS && wr_ena && (wr_addr != ZERO_REG)
                && (rd_addr1 == wr_addr);

  always_comb begin
    rd_data0 = rf[rd_addr0];
    if (fwd0) rd_data0 = wr_data;
  end

  always_comb begin
    rd_data1 = rf[rd_addr1];
    if (fwd1) rd_data1 = wr_data;
  end

endmodule
